// File: rtl/div_defs_pkg.sv
// Shared divider definitions: sequencer state encoding, step count and operand sign helpers.
// Also imported by the hazard unit so both agree on the divide latency.
package div_defs_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divStateT;

    // Magnitude of a two's-complement operand; 0x80000000 maps onto itself as an unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isSigned);
        logic [31:0] mag;
        if (isSigned && value[31]) begin
            mag = 32'd0 - value;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    function automatic logic [31:0] condNegate(input logic [31:0] value, input logic negate);
        logic [31:0] res;
        if (negate) begin
            res = 32'd0 - value;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract divide step, purely combinational.
module div_step (
    input  logic [31:0] remIn,
    input  logic [31:0] quoIn,
    input  logic [31:0] divisorIn,
    output logic [31:0] remOut,
    output logic [31:0] quoOut
);
    logic [32:0] trial;
    logic [32:0] diff;

    // remIn < divisorIn always holds, so diff fits in 32 bits whenever no borrow occurs.
    always_comb begin
        trial = {remIn, quoIn[31]};
        diff  = trial - {1'b0, divisorIn};
        if (!diff[32]) begin
            remOut = diff[31:0];
            quoOut = {quoIn[30:0], 1'b1};
        end else begin
            remOut = trial[31:0];
            quoOut = {quoIn[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned 32-bit divider sequencer with pipeline stall and E-stage cancel.
module div_sequencer
    import div_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);
    localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

    divStateT    stateR;
    divStateT    stateNext;
    logic [5:0]  countR;
    logic [31:0] remR;
    logic [31:0] quoR;
    logic [31:0] divisorR;
    logic        dividendSignR;
    logic        divisorSignR;
    logic        signedR;
    logic        accept;
    logic [31:0] stepRem;
    logic [31:0] stepQuo;
    logic [31:0] fixQuo;
    logic [31:0] fixRem;

    div_step u_step (
        .remIn     (remR),
        .quoIn     (quoR),
        .divisorIn (divisorR),
        .remOut    (stepRem),
        .quoOut    (stepQuo)
    );

    // Next-state decode, operand acceptance and the stall request.
    always_comb begin
        stateNext = stateR;
        accept    = 1'b0;
        stall     = 1'b0;
        case (stateR)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    stall  = 1'b1;
                    if (divisor == 32'd0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = BUSY;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (countR == LAST_STEP) begin
                    stateNext = DONE;
                end else begin
                    stateNext = BUSY;
                end
            end
            // The stale start is still present here, so it must not be re-accepted.
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (cancel || rst) begin
            stateNext = IDLE;
            accept    = 1'b0;
            stall     = 1'b0;
        end else begin
            stateNext = stateNext;
        end
    end

    // Sign correction of the final step's result.
    always_comb begin
        fixQuo = condNegate(stepQuo, signedR && (dividendSignR ^ divisorSignR));
        fixRem = condNegate(stepRem, signedR && dividendSignR);
    end

    // State, working registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR        <= IDLE;
            countR        <= 6'd0;
            remR          <= 32'd0;
            quoR          <= 32'd0;
            divisorR      <= 32'd0;
            dividendSignR <= 1'b0;
            divisorSignR  <= 1'b0;
            signedR       <= 1'b0;
            quotient      <= 32'd0;
            remainder     <= 32'd0;
            result_valid  <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            stateR       <= stateNext;
            result_valid <= 1'b0;
            case (stateR)
                IDLE: begin
                    if (accept) begin
                        remR          <= 32'd0;
                        quoR          <= magnitude(dividend, signed_op);
                        divisorR      <= magnitude(divisor, signed_op);
                        dividendSignR <= dividend[31];
                        divisorSignR  <= divisor[31];
                        signedR       <= signed_op;
                        countR        <= 6'd0;
                        if (divisor == 32'd0) begin
                            quotient     <= 32'hFFFF_FFFF;
                            remainder    <= dividend;
                            div_by_zero  <= 1'b1;
                            result_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!cancel) begin
                        remR <= stepRem;
                        quoR <= stepQuo;
                        if (countR == LAST_STEP) begin
                            quotient     <= fixQuo;
                            remainder    <= fixRem;
                            div_by_zero  <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            countR <= countR + 6'd1;
                        end
                    end
                end
                default: begin
                    countR <= countR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, signed fixup, divide-by-zero, cancel, reset.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_op    (signed_op),
        .dividend     (dividend),
        .divisor      (divisor),
        .cancel       (cancel),
        .stall        (stall),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one divide from a negedge; cycle 0 is the accept cycle. Returns at the negedge after result_valid.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int vc, output logic [63:0] sb,
                          output logic [31:0] q, output logic [31:0] r, output logic z);
        vc = -1; sb = '0; q = '0; r = '0; z = 1'b0;
        signed_op = sgn; dividend = a; divisor = b; start = 1'b1;
        for (int c = 0; c < 40 && vc < 0; c++) begin
            #1;
            sb[c] = stall;
            if (result_valid === 1'b1) begin
                vc = c; q = quotient; r = remainder; z = div_by_zero;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; cancel = 1'b0; signed_op = 1'b0;
        dividend = 32'd100; divisor = 32'd7;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_case(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expQ, input logic [31:0] expR, input logic expZ);
        int vc; logic [63:0] sb; logic [31:0] q; logic [31:0] r; logic z;
        int expVc; logic [33:0] expSb;
        expVc = expZ ? 1 : 33;
        expSb = expZ ? 34'h1 : 34'h1_FFFF_FFFF;
        do_div(sgn, a, b, vc, sb, q, r, z);
        checks++; if (vc !== expVc) begin errors++; $display("FAIL %s valid_cycle got=%0d exp=%0d", name, vc, expVc); end
        checks++; if (sb[33:0] !== expSb) begin errors++; $display("FAIL %s stall_pattern got=%h exp=%h", name, sb[33:0], expSb); end
        checks++; if (q !== expQ) begin errors++; $display("FAIL %s quotient got=%h exp=%h", name, q, expQ); end
        checks++; if (r !== expR) begin errors++; $display("FAIL %s remainder got=%h exp=%h", name, r, expR); end
        checks++; if (z !== expZ) begin errors++; $display("FAIL %s div_by_zero got=%b exp=%b", name, z, expZ); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int vc1; int vc2; logic [63:0] sb1; logic [63:0] sb2;
        logic [31:0] q1; logic [31:0] r1; logic [31:0] q2; logic [31:0] r2; logic z1; logic z2;
        do_div(1'b0, 32'd9, 32'd4, vc1, sb1, q1, r1, z1);
        do_div(1'b0, 32'd9, 32'd2, vc2, sb2, q2, r2, z2);
        checks++; if (vc1 !== 33) begin errors++; $display("FAIL b2b_first_cycle got=%0d exp=33", vc1); end
        checks++; if ({q1, r1} !== {32'd2, 32'd1}) begin errors++; $display("FAIL b2b_first_result got=%0d,%0d exp=2,1", q1, r1); end
        checks++; if (vc2 + 34 !== 67) begin errors++; $display("FAIL b2b_second_cycle got=%0d exp=67", vc2 + 34); end
        checks++; if (sb2[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept_stall got=%b exp=1", sb2[0]); end
        checks++; if ({q2, r2} !== {32'd4, 32'd1}) begin errors++; $display("FAIL b2b_second_result got=%0d,%0d exp=4,1", q2, r2); end
        @(negedge clk);
    endtask

    task automatic test_cancel();
        int seen = 0;
        signed_op = 1'b0; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
        for (int c = 0; c < 10; c++) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cancel_busy_stall got=%b exp=1", stall); end
        cancel = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cancel_stall got=%b exp=0", stall); end
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cancel_idle_stall got=%b exp=0", stall); end
        for (int c = 0; c < 40; c++) begin
            if (result_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_no_valid got=%0d pulses exp=0", seen); end
        checks++; if ({quotient, remainder} !== {32'd4, 32'd1}) begin errors++; $display("FAIL cancel_hold got=%h,%h exp=4,1", quotient, remainder); end
    endtask

    task automatic test_reset_mid_busy();
        int seen = 0;
        signed_op = 1'b0; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
        for (int c = 0; c < 20; c++) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstbusy_busy_stall got=%b exp=1", stall); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstbusy_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        checks++; if ({result_valid, div_by_zero, stall} !== 3'b000) begin errors++; $display("FAIL rstbusy_flags got=%b exp=000", {result_valid, div_by_zero, stall}); end
        checks++; if ({quotient, remainder} !== 64'd0) begin errors++; $display("FAIL rstbusy_outputs got=%h,%h exp=0,0", quotient, remainder); end
        for (int c = 0; c < 40; c++) begin
            if (result_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstbusy_no_valid got=%0d pulses exp=0", seen); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_op = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        @(negedge clk);
        test_reset();
        test_case("divu_100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
        test_case("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        test_case("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
        test_case("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
        test_case("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);
        test_case("divu_by_zero", 1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        test_back_to_back();
        test_cancel();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
